// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter/sequencer for the IF and MEM stages: one access at a time, fixed read latency.
// Optional IF anti-starvation counter is enabled with the ARB_FAIRNESS_EN macro.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_be,
  output logic                mem_gnt,
  output logic                mem_rvalid,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                ram_en,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic [DATA_W/8-1:0] ram_be,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic                busy
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;
  typedef enum logic {OWN_IF, OWN_MEM} owner_e;

  if (MEM_LAT < 1 || MEM_LAT > 15 || STARVE_MAX < 1) begin : g_bad_params
    $error("mem_port_arbiter: MEM_LAT must be 1..15 and STARVE_MAX at least 1");
  end

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                st_q, st_d;
  logic                busy_q, busy_d;
  logic                if_gnt_q, if_gnt_d, mem_gnt_q, mem_gnt_d;
  logic                if_rvalid_q, if_rvalid_d, mem_rvalid_q, mem_rvalid_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
  logic                ram_en_q, ram_en_d, ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic [BE_W-1:0]     ram_be_q, ram_be_d;
  logic                starve_hit_c;
  logic                pick_mem_c;

  // MEM has priority unless IF has been passed over STARVE_MAX times in a row
  assign pick_mem_c = mem_req && !(starve_hit_c && if_req);

`ifdef ARB_FAIRNESS_EN
  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);
  logic [STARVE_W-1:0] starve_q, starve_d;

  assign starve_hit_c = (starve_q == STARVE_W'(STARVE_MAX));

  always_comb begin
    starve_d = starve_q;
    if (state_q == S_IDLE && (mem_req || if_req))
      starve_d = (pick_mem_c && if_req) ? starve_q + STARVE_W'(1) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) starve_q <= '0;
    else      starve_q <= starve_d;
  end
`else
  assign starve_hit_c = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    st_d         = st_q;
    busy_d       = busy_q;
    if_gnt_d     = 1'b0;
    mem_gnt_d    = 1'b0;
    if_rvalid_d  = 1'b0;
    mem_rvalid_d = 1'b0;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;
    ram_en_d     = 1'b0;
    ram_we_d     = 1'b0;
    ram_addr_d   = '0;
    ram_wdata_d  = '0;
    ram_be_d     = '0;
    case (state_q)
      S_IDLE: begin
        if (mem_req || if_req) begin
          state_d  = S_ISSUE;
          busy_d   = 1'b1;
          ram_en_d = 1'b1;
          if (pick_mem_c) begin
            owner_d     = OWN_MEM;
            mem_gnt_d   = 1'b1;
            st_d        = mem_we;
            ram_we_d    = mem_we;
            ram_addr_d  = mem_addr;
            ram_wdata_d = mem_wdata;
            ram_be_d    = mem_we ? mem_be : '0;
          end else begin
            owner_d    = OWN_IF;
            if_gnt_d   = 1'b1;
            st_d       = 1'b0;
            ram_addr_d = if_addr;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        // last WAIT cycle: ram_rdata is valid at its closing edge
        if (cnt_q == CNT_W'(MEM_LAT - 1)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
          if (owner_q == OWN_MEM) begin
            mem_rvalid_d = 1'b1;
            mem_rdata_d  = st_q ? '0 : ram_rdata;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = ram_rdata;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_MEM;
      cnt_q        <= '0;
      st_q         <= 1'b0;
      busy_q       <= 1'b0;
      if_gnt_q     <= 1'b0;
      mem_gnt_q    <= 1'b0;
      if_rvalid_q  <= 1'b0;
      mem_rvalid_q <= 1'b0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ram_be_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      st_q         <= st_d;
      busy_q       <= busy_d;
      if_gnt_q     <= if_gnt_d;
      mem_gnt_q    <= mem_gnt_d;
      if_rvalid_q  <= if_rvalid_d;
      mem_rvalid_q <= mem_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      ram_be_q     <= ram_be_d;
    end
  end

  assign if_gnt     = if_gnt_q;
  assign if_rvalid  = if_rvalid_q;
  assign if_rdata   = if_rdata_q;
  assign mem_gnt    = mem_gnt_q;
  assign mem_rvalid = mem_rvalid_q;
  assign mem_rdata  = mem_rdata_q;
  assign ram_en     = ram_en_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign ram_be     = ram_be_q;
  assign busy       = busy_q;

endmodule
